// File: rtl/pipe_pkg.sv
// Shared pipeline constants: Tuse/Tnew encoding, register zero,
// default mult/div latencies and the RAW hazard compare helper.
package pipe_pkg;

  localparam int T_W = 2;
  typedef logic [T_W-1:0] tval_t;

  localparam tval_t TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W_DEF = 4;

  // A source register is hazardous when a producer in E or M
  // will not have its result forwardable by the time D needs it.
  // TUSE_NONE (3) is never below any Tnew, so unread sources drop out.
  function automatic logic reg_haz(
    input logic [4:0] src,
    input tval_t tuse,
    input logic [4:0] e_wa,
    input tval_t e_tnew,
    input logic [4:0] m_wa,
    input tval_t m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_wa) && (tuse < e_tnew);
    m_hit = (src == m_wa) && (tuse < m_tnew);
    return (src != REG_ZERO) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_tracker.sv
// Mult/div busy tracker: down-counter loaded when a mult/div leaves E.
// Ports: clk, reset, e_md_start, e_md_is_div in; md_busy, md_cnt out.
module md_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new start always reloads, even if the old count has not
  // drained; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (e_md_start) begin
      cnt_d = e_md_is_div ? CNT_W'(DIV_CYCLES)
                          : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = e_md_start || (cnt_q != '0);
  assign md_cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: Tuse/Tnew RAW hazards plus mult/div busy.
// Ports: D/E/M register info in; stall_pc, stall_fd, flush_de,
// md_busy, md_cnt out. PIPE_HAZARD_PERF_EN adds perf stall counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_uses_md,
  input  logic [4:0]       e_wa,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       m_tnew,
  input  logic             e_md_start,
  input  logic             e_md_is_div,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             flush_de,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_md_stall_cnt
`endif
);

  logic rs_haz;
  logic rt_haz;
  logic md_stall;
  logic stall;

  md_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md (
    .clk        (clk),
    .reset      (reset),
    .e_md_start (e_md_start),
    .e_md_is_div(e_md_is_div),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt)
  );

  always_comb begin
    rs_haz = reg_haz(d_rs, d_tuse_rs, e_wa, e_tnew,
                     m_wa, m_tnew);
    rt_haz = reg_haz(d_rt, d_tuse_rt, e_wa, e_tnew,
                     m_wa, m_tnew);
    md_stall = d_uses_md && md_busy;
    stall = rs_haz || rt_haz || md_stall;
  end

  // Pipeline registers sample these at the next edge, so they stay
  // combinational; reset masks them so no stale hazard freezes PC.
  assign stall_pc = stall && !reset;
  assign stall_fd = stall && !reset;
  assign flush_de = stall && !reset;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;
  logic [31:0] perf_md_q;
  logic [31:0] perf_md_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall};
    perf_md_d = perf_md_q + {31'd0, md_stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_md_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_md_q <= perf_md_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_md_stall_cnt = perf_md_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: hazard vector table
// plus mult/div countdown, reload and reset sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_uses_md, e_md_start, e_md_is_div;
  logic       stall_pc, stall_fd, flush_de, md_busy;
  logic [3:0] md_cnt;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_md_stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_uses_md  (d_uses_md),
    .e_wa       (e_wa),
    .e_tnew     (e_tnew),
    .m_wa       (m_wa),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_is_div(e_md_is_div),
    .stall_pc   (stall_pc),
    .stall_fd   (stall_fd),
    .flush_de   (flush_de),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt),
    .perf_md_stall_cnt(perf_md_stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tus;
    logic [1:0] tut;
    logic       umd;
    logic [4:0] ewa;
    logic [1:0] etn;
    logic [4:0] mwa;
    logic [1:0] mtn;
    logic       stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
    d_uses_md = 0; e_wa = 0; e_tnew = 0; m_wa = 0; m_tnew = 0;
    e_md_start = 0; e_md_is_div = 0;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, ".stall_pc"}, {31'd0, stall_pc}, {31'd0, exp});
    chk({name, ".stall_fd"}, {31'd0, stall_fd}, {31'd0, exp});
    chk({name, ".flush_de"}, {31'd0, flush_de}, {31'd0, exp});
  endtask

  initial begin
    //         rs rt tus tut umd ewa etn mwa mtn stall
    vecs[0] = '{8, 0, 1, 3, 0, 8, 2, 0, 0, 1};  // load-use
    vecs[1] = '{8, 0, 1, 3, 0, 0, 0, 8, 1, 0};  // lw now in M
    vecs[2] = '{0, 0, 0, 0, 0, 0, 2, 0, 0, 0};  // zero reg E
    vecs[3] = '{0, 5, 3, 0, 0, 0, 0, 5, 1, 1};  // rt vs M
    vecs[4] = '{8, 0, 3, 3, 0, 8, 2, 0, 0, 0};  // rs unread
    vecs[5] = '{8, 0, 2, 3, 0, 8, 2, 0, 0, 0};  // tuse==tnew
    vecs[6] = '{9, 0, 0, 3, 0, 8, 2, 0, 0, 0};  // other reg
    vecs[7] = '{0, 0, 3, 3, 1, 0, 0, 0, 0, 0};  // md idle
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0};  // zero reg M
    vecs[9] = '{3, 4, 0, 1, 0, 3, 1, 4, 2, 1};  // both srcs

    idle();
    reset = 1'b1;
    @(negedge clk);
    d_rs = 8; d_tuse_rs = 0; e_wa = 8; e_tnew = 2;
    @(negedge clk);
    #1;
    chk("rst.md_cnt", {28'd0, md_cnt}, 32'd0);
    chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
    chk_stall("rst.hazard_masked", 1'b0);
    reset = 1'b0;
    idle();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      d_rs = vecs[i].rs; d_rt = vecs[i].rt;
      d_tuse_rs = vecs[i].tus; d_tuse_rt = vecs[i].tut;
      d_uses_md = vecs[i].umd;
      e_wa = vecs[i].ewa; e_tnew = vecs[i].etn;
      m_wa = vecs[i].mwa; m_tnew = vecs[i].mtn;
      #1;
      chk_stall($sformatf("vec%0d", i), vecs[i].stall);
    end

    // clean reset so perf counters start at zero
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // mult: start at cycle 0, mfhi in D from cycle 1
    e_md_start = 1;
    #1;
    chk("mul.c0.busy", {31'd0, md_busy}, 32'd1);
    chk("mul.c0.cnt", {28'd0, md_cnt}, 32'd0);
    chk_stall("mul.c0", 1'b0);
    @(negedge clk);
    e_md_start = 0;
    d_uses_md = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("mul.c%0d.cnt", k + 1), {28'd0, md_cnt},
          32'(5 - k));
      chk_stall($sformatf("mul.c%0d", k + 1), 1'b1);
      @(negedge clk);
    end
    #1;
    chk("mul.c6.cnt", {28'd0, md_cnt}, 32'd0);
    chk("mul.c6.busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mul.c6", 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf.stall", perf_stall_cnt, 32'd5);
    chk("perf.md", perf_md_stall_cnt, 32'd5);
`endif

    // div with unrelated instruction in D
    @(negedge clk);
    idle();
    e_md_start = 1; e_md_is_div = 1;
    #1;
    chk("div.c0.busy", {31'd0, md_busy}, 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      e_md_start = 0;
      #1;
      chk($sformatf("div.c%0d.busy", c), {31'd0, md_busy}, 32'd1);
      chk($sformatf("div.c%0d.cnt", c), {28'd0, md_cnt},
          32'(11 - c));
      chk_stall($sformatf("div.c%0d", c), 1'b0);
    end
    @(negedge clk);
    #1;
    chk("div.c11.busy", {31'd0, md_busy}, 32'd0);

    // restart during countdown: reload wins
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1;
    @(negedge clk);
    e_md_start = 0;
    @(negedge clk);
    #1;
    chk("reload.pre", {28'd0, md_cnt}, 32'd9);
    e_md_start = 1; e_md_is_div = 0;
    @(negedge clk);
    e_md_start = 0;
    #1;
    chk("reload.cnt", {28'd0, md_cnt}, 32'd5);

    // reset at md_cnt = 7
    @(negedge clk);
    e_md_start = 1; e_md_is_div = 1;
    @(negedge clk);
    e_md_start = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstmid.pre", {28'd0, md_cnt}, 32'd7);
    reset = 1;
    d_uses_md = 1;
    d_rs = 8; d_tuse_rs = 0; e_wa = 8; e_tnew = 2;
    #1;
    chk_stall("rstmid.hi", 1'b0);
    @(negedge clk);
    #1;
    chk("rstmid.cnt", {28'd0, md_cnt}, 32'd0);
    chk("rstmid.busy", {31'd0, md_busy}, 32'd0);
    chk_stall("rstmid.after", 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf.rst.stall", perf_stall_cnt, 32'd0);
    chk("perf.rst.md", perf_md_stall_cnt, 32'd0);
`endif
    reset = 0;
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline. It drives the freeze of the PC and F/D register and the bubble (clear) input of the D/E register.
- Detects read-after-write hazards that forwarding cannot cover, using the Tuse/Tnew scheme.
- Tracks the multi-cycle multiply/divide unit with a busy down-counter, so HI/LO-dependent instructions wait in D until the result is ready.

Parameters:
- MULT_CYCLES, 5, cycles HI/LO stay busy after a mult/multu leaves E.
- DIV_CYCLES, 10, cycles HI/LO stay busy after a div/divu leaves E.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_rs  in  5  rs register number of the instruction in D
- d_rt  in  5  rt register number of the instruction in D
- d_tuse_rs  in  2  cycles until D instr needs rs; 3 = rs not read
- d_tuse_rt  in  2  cycles until D instr needs rt; 3 = rt not read
- d_uses_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- e_wa  in  5  destination register of the instr in E; 0 = none
- e_tnew  in  2  cycles until E result is forwardable
- m_wa  in  5  destination register of the instr in M
- m_tnew  in  2  cycles until M result is forwardable
- e_md_start  in  1  mult/div instr occupies E this cycle
- e_md_is_div  in  1  qualifies e_md_start: 1 = div/divu
- stall_pc  out  1  hold PC
- stall_fd  out  1  hold F/D register
- flush_de  out  1  load bubble (all zeros) into D/E register
- md_busy  out  1  mult/div unit busy
- md_cnt  out  CNT_W  remaining busy cycles

Behaviour:
- Hazard terms (combinational):
  - rs_haz = (d_rs != 0) && ((d_rs == e_wa && d_tuse_rs < e_tnew) || (d_rs == m_wa && d_tuse_rs < m_tnew)).
  - rt_haz is the same with d_rt and d_tuse_rt.
  - Register 0 never causes a hazard.
- Busy counter cnt (registered):
  - Reset: 0.
  - Each edge: if e_md_start, load DIV_CYCLES when e_md_is_div, else MULT_CYCLES. Else if cnt != 0, decrement. Else hold at 0.
  - e_md_start while cnt != 0 (illegal, since D stalls): the reload wins.
  - No wrap-around: cnt saturates at 0.
- Outputs:
  - md_busy = e_md_start || (cnt != 0).
  - md_cnt = cnt.
  - md_stall = d_uses_md && md_busy.
  - stall = rs_haz || rt_haz || md_stall.
  - stall_pc = stall_fd = flush_de = stall, all in the same cycle. Outputs are combinational because the pipeline registers sample them at the next edge.
- Latency: a mult leaving E at cycle t keeps md_busy high for cycles t..t+MULT_CYCLES.
- Reset:
  - While reset is high, stall_pc, stall_fd and flush_de are forced to 0, and md_busy/md_cnt read 0 after the reset edge.
  - Reset mid-countdown clears cnt immediately at that edge.
- A flushed bubble in E has e_md_start = 0 and e_wa = 0, so it never self-extends a stall.
- Priority: reset > e_md_start load > decrement.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_md_stall_cnt [31:0].
  - Each increments by 1 on every clock edge where stall (resp. md_stall) is 1 and reset is 0.
  - Both wrap from 0xFFFFFFFF to 0 and clear to 0 on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - TUSE_NONE = 2'd3 and the Tnew/Tuse width.
  - REG_ZERO = 5'd0.
  - Default MULT_CYCLES/DIV_CYCLES constants.
- Sub-module md_busy_tracker: holds the counter, load/decrement logic and md_busy. pipe_hazard_ctrl instantiates it and adds the hazard compare logic.

Test Plan:
- Load-use: E = lw writing $8 (e_wa = 8, e_tnew = 2); D reads rs = 8 with tuse_rs = 1 → stall/flush high for 1 cycle. Next cycle m_wa = 8, m_tnew = 1 → no stall.
- Zero register: e_wa = 0, d_rs = 0, e_tnew = 2, tuse = 0 → stall stays 0.
- Mult busy: e_md_start = 1, e_md_is_div = 0 at cycle 0; mfhi in D from cycle 1 → stall cycles 1–5, md_cnt reads 5, 4, 3, 2, 1, released at cycle 6.
- Div busy: DIV_CYCLES = 10; non-md instr in D during countdown → no stall while md_busy = 1 for cycles 0–10.
- Reset mid-operation: assert reset at md_cnt = 7 → md_cnt = 0 and md_busy = 0 after that edge; all stall outputs are 0 while reset is high.
- PIPE_HAZARD_PERF_EN: repeat the mult scenario → perf_stall_cnt = 5 and perf_md_stall_cnt = 5; reset → both 0.
